calc_op_sequencer: RTL

Sequences a single calculator operation between the keypad decoder and the processor's shared data memory. Accumulates decimal keystrokes into two 32-bit operands and an operator, writes them into a fixed mailbox in memory, and starts the processor. It then waits for completion, reads the result back, and chains that result into the next operation. It sits between the click/keypad decoder and the memory write port, and also supplies the display value to the VGA painter.

---
 rtl/calc_op_sequencer.sv | 306 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/calc_op_sequencer.sv
// -----------------------------------------------------------------------------
// calc_op_sequencer
//
// Sequences one calculator operation between the keypad decoder and the
// processor's shared data memory. Decimal keystrokes build operand A, an
// operator, and operand B. The sequencer writes them into a fixed mailbox,
// starts the processor, waits for completion and reads the result back. That
// result then becomes operand A of the next operation.
//
// Mailbox words, relative to BASE_ADDR:
//   +0  A
//   +4  op
//   +8  B
//   +12 result
//
// Optional feature macro: CALC_TIMEOUT_EN
//   When defined, WAIT_DONE gives up after TIMEOUT cycles. It then sets the
//   sticky error flag and returns to operand entry.
//   When undefined, WAIT_DONE waits indefinitely and error stays low.
//
// Ports:
//   CLK_100MHZ   in   system clock, rising edge
//   reset        in   asynchronous active-high reset
//   key_valid    in   key is valid this cycle
//   key[3:0]     in   0-9 digit, 10 add, 11 sub, 12 mul, 13 equals,
//                     14 ignored, 15 clear
//   mem_addr     out  memory byte address
//   mem_wdata    out  memory write data
//   mem_we       out  memory write enable
//   mem_rdata    in   memory read data, valid one cycle after mem_addr
//   cpu_start    out  one-cycle pulse: mailbox loaded
//   cpu_done     in   level: processor has written the result
//   result       out  last result read back
//   result_valid out  one-cycle pulse while the result is captured
//   disp_value   out  value for the display painter
//   disp_digits  out  digits entered in the current operand
//   busy         out  high from WR_A through RD_CAP
//   error        out  sticky timeout flag
//
// All outputs are registered. They are computed from the next-state values, so
// each output lines up with the state it belongs to.
// -----------------------------------------------------------------------------
module calc_op_sequencer #(
    parameter int          MAX_DIGITS = 9,
    parameter logic [31:0] BASE_ADDR  = 32'h0,
    parameter int          TIMEOUT    = 1023
) (
    input  logic        CLK_100MHZ,
    input  logic        reset,
    input  logic        key_valid,
    input  logic [3:0]  key,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    input  logic [31:0] mem_rdata,
    output logic        cpu_start,
    input  logic        cpu_done,
    output logic [31:0] result,
    output logic        result_valid,
    output logic [31:0] disp_value,
    output logic [3:0]  disp_digits,
    output logic        busy,
    output logic        error
);

    localparam logic [3:0] ENTRY_A   = 4'd0;
    localparam logic [3:0] ENTRY_B   = 4'd1;
    localparam logic [3:0] WR_A      = 4'd2;
    localparam logic [3:0] WR_OP     = 4'd3;
    localparam logic [3:0] WR_B      = 4'd4;
    localparam logic [3:0] START     = 4'd5;
    localparam logic [3:0] WAIT_DONE = 4'd6;
    localparam logic [3:0] RD_ADDR   = 4'd7;
    localparam logic [3:0] RD_CAP    = 4'd8;
    localparam logic [3:0] SHOW      = 4'd9;

    localparam logic [3:0] MAX_CNT = 4'(MAX_DIGITS);

    logic [3:0]  state, state_n;
    logic [31:0] op_a, op_a_n;
    logic [31:0] op_b, op_b_n;
    logic [1:0]  op, op_n;
    logic [3:0]  cnt, cnt_n;
    logic [31:0] result_n;
    logic [31:0] mem_addr_n, mem_wdata_n, disp_value_n;
    logic        mem_we_n, cpu_start_n, result_valid_n, busy_n;
    logic [3:0]  key_op;
    logic [31:0] key_ext;

    assign key_op  = key - 4'd10;   // add/sub/mul -> 0/1/2 in the low bits
    assign key_ext = {28'd0, key};

`ifdef CALC_TIMEOUT_EN
    localparam int TCW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    logic [TCW-1:0] tcnt, tcnt_n;
    logic           error_n;
`else
    // No watchdog: the flag is a constant low. TIMEOUT is negative only for a
    // nonsense configuration.
    assign error = (TIMEOUT < 0);
`endif

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_n  = state;
        op_a_n   = op_a;
        op_b_n   = op_b;
        op_n     = op;
        cnt_n    = cnt;
        result_n = result;
`ifdef CALC_TIMEOUT_EN
        tcnt_n   = '0;
        error_n  = error;
`endif
        case (state)
            ENTRY_A, ENTRY_B: begin
                if (key_valid) begin
                    case (key)
                        4'd0, 4'd1, 4'd2, 4'd3, 4'd4,
                        4'd5, 4'd6, 4'd7, 4'd8, 4'd9: begin
                            // Digits past the limit are dropped silently.
                            if (cnt < MAX_CNT) begin
                                if (state == ENTRY_A) begin
                                    op_a_n = op_a * 32'd10 + key_ext;
                                end else begin
                                    op_b_n = op_b * 32'd10 + key_ext;
                                end
                                cnt_n = cnt + 4'd1;
                            end else begin
                                cnt_n = cnt;
                            end
                        end
                        4'd10, 4'd11, 4'd12: begin
                            // In ENTRY_B an operator may only replace the
                            // latched one before any B digit is typed.
                            if (state == ENTRY_A) begin
                                op_n    = key_op[1:0];
                                cnt_n   = 4'd0;
                                state_n = ENTRY_B;
                            end else if (cnt == 4'd0) begin
                                op_n = key_op[1:0];
                            end else begin
                                op_n = op;
                            end
                        end
                        4'd13: begin
                            if (state == ENTRY_B) begin
                                state_n = WR_A;
                            end else begin
                                state_n = state;
                            end
                        end
                        4'd15: begin
                            op_a_n  = 32'd0;
                            op_b_n  = 32'd0;
                            op_n    = 2'd0;
                            cnt_n   = 4'd0;
                            state_n = ENTRY_A;
`ifdef CALC_TIMEOUT_EN
                            error_n = 1'b0;
`endif
                        end
                        default: state_n = state;
                    endcase
                end else begin
                    state_n = state;
                end
            end
            WR_A:  state_n = WR_OP;
            WR_OP: state_n = WR_B;
            WR_B:  state_n = START;
            START: state_n = WAIT_DONE;
            WAIT_DONE: begin
                if (cpu_done) begin
                    state_n = RD_ADDR;
                end else begin
`ifdef CALC_TIMEOUT_EN
                    // Give up after TIMEOUT cycles here without completion.
                    if (tcnt == TCW'(TIMEOUT - 1)) begin
                        error_n = 1'b1;
                        op_a_n  = 32'd0;
                        op_b_n  = 32'd0;
                        op_n    = 2'd0;
                        cnt_n   = 4'd0;
                        state_n = ENTRY_A;
                    end else begin
                        tcnt_n = tcnt + 1'b1;
                    end
`else
                    state_n = WAIT_DONE;
`endif
                end
            end
            RD_ADDR: state_n = RD_CAP;
            RD_CAP: begin
                // The result becomes operand A of the next operation.
                result_n = mem_rdata;
                op_a_n   = mem_rdata;
                op_b_n   = 32'd0;
                cnt_n    = 4'd0;
                state_n  = SHOW;
            end
            SHOW: begin
                if (key_valid) begin
                    case (key)
                        4'd0, 4'd1, 4'd2, 4'd3, 4'd4,
                        4'd5, 4'd6, 4'd7, 4'd8, 4'd9: begin
                            op_a_n  = key_ext;
                            cnt_n   = 4'd1;
                            state_n = ENTRY_A;
                        end
                        4'd10, 4'd11, 4'd12: begin
                            op_n    = key_op[1:0];
                            cnt_n   = 4'd0;
                            state_n = ENTRY_B;
                        end
                        4'd15: begin
                            op_a_n  = 32'd0;
                            op_b_n  = 32'd0;
                            op_n    = 2'd0;
                            cnt_n   = 4'd0;
                            state_n = ENTRY_A;
`ifdef CALC_TIMEOUT_EN
                            error_n = 1'b0;
`endif
                        end
                        default: state_n = SHOW;
                    endcase
                end else begin
                    state_n = SHOW;
                end
            end
            default: state_n = ENTRY_A;
        endcase

        mem_we_n       = (state_n == WR_A) || (state_n == WR_OP) || (state_n == WR_B);
        cpu_start_n    = (state_n == START);
        result_valid_n = (state_n == RD_CAP);
        busy_n         = (state_n >= WR_A) && (state_n <= RD_CAP);

        case (state_n)
            WR_A:    begin mem_addr_n = BASE_ADDR;          mem_wdata_n = op_a_n;          end
            WR_OP:   begin mem_addr_n = BASE_ADDR + 32'd4;  mem_wdata_n = {30'd0, op_n};   end
            WR_B:    begin mem_addr_n = BASE_ADDR + 32'd8;  mem_wdata_n = op_b_n;          end
            RD_ADDR: begin mem_addr_n = BASE_ADDR + 32'd12; mem_wdata_n = 32'd0;           end
            default: begin mem_addr_n = 32'd0;              mem_wdata_n = 32'd0;           end
        endcase

        // While busy the display holds whatever the last entry state showed.
        case (state_n)
            ENTRY_A: disp_value_n = op_a_n;
            ENTRY_B: disp_value_n = (cnt_n == 4'd0) ? op_a_n : op_b_n;
            SHOW:    disp_value_n = result_n;
            default: disp_value_n = disp_value;
        endcase
    end

    // State, datapath and output registers.
    always_ff @(posedge CLK_100MHZ or posedge reset) begin
        if (reset) begin
            state        <= ENTRY_A;
            op_a         <= 32'd0;
            op_b         <= 32'd0;
            op           <= 2'd0;
            cnt          <= 4'd0;
            result       <= 32'd0;
            mem_addr     <= 32'd0;
            mem_wdata    <= 32'd0;
            mem_we       <= 1'b0;
            cpu_start    <= 1'b0;
            result_valid <= 1'b0;
            disp_value   <= 32'd0;
            disp_digits  <= 4'd0;
            busy         <= 1'b0;
        end else begin
            state        <= state_n;
            op_a         <= op_a_n;
            op_b         <= op_b_n;
            op           <= op_n;
            cnt          <= cnt_n;
            result       <= result_n;
            mem_addr     <= mem_addr_n;
            mem_wdata    <= mem_wdata_n;
            mem_we       <= mem_we_n;
            cpu_start    <= cpu_start_n;
            result_valid <= result_valid_n;
            disp_value   <= disp_value_n;
            disp_digits  <= cnt_n;
            busy         <= busy_n;
        end
    end

`ifdef CALC_TIMEOUT_EN
    // Watchdog counter and sticky error flag.
    always_ff @(posedge CLK_100MHZ or posedge reset) begin
        if (reset) begin
            tcnt  <= '0;
            error <= 1'b0;
        end else begin
            tcnt  <= tcnt_n;
            error <= error_n;
        end
    end
`endif

endmodule
